// File: rtl/sdram_responder.sv
// SDR SDRAM device emulator: decodes the command bus, tracks the init sequence,
// mode register and per-bank open rows, stores data in a small backing memory
// and returns read data at the programmed CAS latency. Errors are sticky.
module sdram_responder #(
  parameter int ROW_WIDTH      = 13,
  parameter int COL_WIDTH      = 9,
  parameter int BANK_WIDTH     = 2,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int SDRADDR_WIDTH  = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clock_enable,
  input  logic                     cs_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic [SDRADDR_WIDTH-1:0] addr,
  input  logic [BANK_WIDTH-1:0]    bank_addr,
  input  logic [15:0]              data_in,
  input  logic                     data_mask_low,
  input  logic                     data_mask_high,
  output logic [15:0]              data_out,
  output logic                     data_oe,
  output logic                     init_done,
  output logic [9:0]               mode_reg,
  output logic [15:0]              refresh_count,
  output logic                     err_not_init,
  output logic                     err_no_row,
  output logic                     err_act_open,
  output logic                     err_ref_open,
  output logic                     err_mode
);

  localparam int NumBanks     = 1 << BANK_WIDTH;
  localparam int MemDepth     = 1 << MEM_ADDR_WIDTH;
  localparam int FullIdxWidth = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

  typedef enum logic [2:0] {
    StWaitPall,
    StWaitRef1,
    StWaitRef2,
    StWaitMrs,
    StReady
  } init_state_e;

  typedef enum logic [2:0] {
    CmdMrs   = 3'b000,
    CmdRef   = 3'b001,
    CmdPre   = 3'b010,
    CmdAct   = 3'b011,
    CmdWrite = 3'b100,
    CmdRead  = 3'b101,
    CmdBst   = 3'b110,
    CmdNop   = 3'b111
  } cmd_e;

  init_state_e state_q, state_d;
  cmd_e        cmd;
  logic        ready;
  logic        not_init_cmd;
  logic        mrs_cmd;
  logic        cl3;

  logic [NumBanks-1:0]  bank_open_q, bank_open_d;
  logic [ROW_WIDTH-1:0] row_q [NumBanks];
  logic [ROW_WIDTH-1:0] row_d [NumBanks];
  logic [9:0]           mode_reg_q, mode_reg_d;
  logic [15:0]          refresh_count_q, refresh_count_d;
  logic err_not_init_q, err_not_init_d;
  logic err_no_row_q, err_no_row_d;
  logic err_act_open_q, err_act_open_d;
  logic err_ref_open_q, err_ref_open_d;
  logic err_mode_q, err_mode_d;

  // Two read stages ahead of the output register: CL2 enters stage 0, CL3 stage 1.
  logic        rd0_vld_q, rd0_vld_d, rd1_vld_q, rd1_vld_d;
  logic [15:0] rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
  logic        data_oe_q, data_oe_d;
  logic [15:0] data_out_q, data_out_d;

  logic [15:0]             mem [MemDepth];
  logic [FullIdxWidth-1:0] full_idx;
  logic [MEM_ADDR_WIDTH-1:0] mem_idx;
  logic [15:0]             rd_word;
  logic                    bank_is_open;

  // Command decode; deselect or clock-disable looks like NOP. Burst stop is ignored.
  always_comb begin
    cmd = cmd_e'({ras_n, cas_n, we_n});
    if (!clock_enable || cs_n || cmd == CmdBst) begin
      cmd = CmdNop;
    end
  end

  assign ready        = (state_q == StReady);
  assign mrs_cmd      = (cmd == CmdMrs) && (state_q == StWaitMrs || ready);
  assign cl3          = (mode_reg_q[6:4] == 3'd3);
  assign bank_is_open = bank_open_q[bank_addr];
  assign full_idx     = {bank_addr, row_q[bank_addr], addr[COL_WIDTH-1:0]};
  assign mem_idx      = MEM_ADDR_WIDTH'(full_idx);
  assign rd_word      = bank_is_open ? mem[mem_idx] : 16'h0000;

  // Init sequence: each step waits for its one command; anything else but NOP is an error.
  always_comb begin
    state_d      = state_q;
    not_init_cmd = 1'b0;
    case (state_q)
      StWaitPall: begin
        if (cmd == CmdPre && addr[10]) state_d = StWaitRef1;
        else if (cmd != CmdNop)        not_init_cmd = 1'b1;
      end
      StWaitRef1: begin
        if (cmd == CmdRef)      state_d = StWaitRef2;
        else if (cmd != CmdNop) not_init_cmd = 1'b1;
      end
      StWaitRef2: begin
        if (cmd == CmdRef)      state_d = StWaitMrs;
        else if (cmd != CmdNop) not_init_cmd = 1'b1;
      end
      StWaitMrs: begin
        if (cmd == CmdMrs)      state_d = StReady;
        else if (cmd != CmdNop) not_init_cmd = 1'b1;
      end
      StReady: state_d = StReady;
      default: state_d = StWaitPall;
    endcase
  end

  // Bank tracking, mode register, refresh counter and sticky error flags.
  always_comb begin
    bank_open_d     = bank_open_q;
    row_d           = row_q;
    mode_reg_d      = mode_reg_q;
    refresh_count_d = refresh_count_q;
    err_not_init_d  = err_not_init_q | not_init_cmd;
    err_no_row_d    = err_no_row_q;
    err_act_open_d  = err_act_open_q;
    err_ref_open_d  = err_ref_open_q;
    err_mode_d      = err_mode_q;
    if (mrs_cmd) begin
      mode_reg_d = addr[9:0];
      if (!(addr[6:4] == 3'd2 || addr[6:4] == 3'd3) || addr[2:0] != 3'b000) begin
        err_mode_d = 1'b1;
      end
      if (|bank_open_q) err_act_open_d = 1'b1;
    end
    if (ready) begin
      case (cmd)
        CmdAct: begin
          if (bank_is_open) begin
            err_act_open_d = 1'b1;
          end else begin
            bank_open_d[bank_addr] = 1'b1;
            row_d[bank_addr]       = addr[ROW_WIDTH-1:0];
          end
        end
        CmdPre: begin
          if (addr[10]) bank_open_d = '0;
          else          bank_open_d[bank_addr] = 1'b0;
        end
        CmdRead, CmdWrite: begin
          if (!bank_is_open) err_no_row_d = 1'b1;
          if (addr[10])      bank_open_d[bank_addr] = 1'b0;
        end
        CmdRef: begin
          if (refresh_count_q != 16'hFFFF) refresh_count_d = refresh_count_q + 16'd1;
          if (|bank_open_q) err_ref_open_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read pipeline; data_out only changes when a read word reaches the output.
  always_comb begin
    rd1_vld_d  = 1'b0;
    rd1_data_d = rd1_data_q;
    rd0_vld_d  = rd1_vld_q;
    rd0_data_d = rd1_data_q;
    if (ready && cmd == CmdRead) begin
      if (cl3) begin
        rd1_vld_d  = 1'b1;
        rd1_data_d = rd_word;
      end else begin
        rd0_vld_d  = 1'b1;
        rd0_data_d = rd_word;
      end
    end
    data_oe_d  = rd0_vld_q;
    data_out_d = rd0_vld_q ? rd0_data_q : data_out_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StWaitPall;
      bank_open_q     <= '0;
      mode_reg_q      <= '0;
      refresh_count_q <= '0;
      err_not_init_q  <= 1'b0;
      err_no_row_q    <= 1'b0;
      err_act_open_q  <= 1'b0;
      err_ref_open_q  <= 1'b0;
      err_mode_q      <= 1'b0;
      rd0_vld_q       <= 1'b0;
      rd1_vld_q       <= 1'b0;
      rd0_data_q      <= '0;
      rd1_data_q      <= '0;
      data_oe_q       <= 1'b0;
      data_out_q      <= '0;
      for (int i = 0; i < NumBanks; i++) row_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      bank_open_q     <= bank_open_d;
      row_q           <= row_d;
      mode_reg_q      <= mode_reg_d;
      refresh_count_q <= refresh_count_d;
      err_not_init_q  <= err_not_init_d;
      err_no_row_q    <= err_no_row_d;
      err_act_open_q  <= err_act_open_d;
      err_ref_open_q  <= err_ref_open_d;
      err_mode_q      <= err_mode_d;
      rd0_vld_q       <= rd0_vld_d;
      rd1_vld_q       <= rd1_vld_d;
      rd0_data_q      <= rd0_data_d;
      rd1_data_q      <= rd1_data_d;
      data_oe_q       <= data_oe_d;
      data_out_q      <= data_out_d;
    end
  end

  // Backing store with per-byte write masks; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && ready && cmd == CmdWrite && bank_is_open) begin
      if (!data_mask_low)  mem[mem_idx][7:0]  <= data_in[7:0];
      if (!data_mask_high) mem[mem_idx][15:8] <= data_in[15:8];
    end
  end

  assign data_out      = data_out_q;
  assign data_oe       = data_oe_q;
  assign init_done     = ready;
  assign mode_reg      = mode_reg_q;
  assign refresh_count = refresh_count_q;
  assign err_not_init  = err_not_init_q;
  assign err_no_row    = err_no_row_q;
  assign err_act_open  = err_act_open_q;
  assign err_ref_open  = err_ref_open_q;
  assign err_mode      = err_mode_q;

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDR SDRAM device emulator that sits on the SDRAM-side pins of the team's SDRAM controller in place of a real chip, for FPGA self-test and simulation. Decodes the command bus, tracks init sequence, mode register and per-bank open rows, stores data in a small on-chip backing memory, and returns read data at the programmed CAS latency. Protocol violations raise sticky error flags.

## Interface
- ROW_WIDTH, 13, row address bits
- COL_WIDTH, 9, column address bits
- BANK_WIDTH, 2, bank address bits (fixed 4 banks)
- MEM_ADDR_WIDTH, 10, backing store depth = 2^MEM_ADDR_WIDTH 16-bit words
- SDRADDR_WIDTH, max(ROW_WIDTH, COL_WIDTH), derived

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- clock_enable, cs_n, ras_n, cas_n, we_n  in  1 each  SDRAM command pins
- addr  in  SDRADDR_WIDTH  row/column/mode address; addr[10] = precharge-all / auto-precharge
- bank_addr  in  BANK_WIDTH  bank select
- data_in  in  16  DQ driven by controller
- data_mask_low, data_mask_high  in  1 each  DQM; 1 masks the byte on writes
- data_out  out  16  read data
- data_oe  out  1  high when data_out is valid (DQ tristate enable)
- init_done  out  1  init sequence completed
- mode_reg  out  10  last MRS value (addr[9:0])
- refresh_count  out  16  REF commands seen after init, saturating
- err_not_init, err_no_row, err_act_open, err_ref_open, err_mode  out  1 each  sticky error flags

## Operation
- Command valid only when clock_enable=1 and cs_n=0; otherwise NOP. {ras_n,cas_n,we_n}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS.
- Init FSM: WAIT_PALL -> (PRE with addr[10]=1) WAIT_REF1 -> (REF) WAIT_REF2 -> (REF) WAIT_MRS -> (MRS) READY. NOPs keep state; any other command before READY sets err_not_init, is otherwise ignored, FSM holds. init_done=1 in READY only.
- MRS (any state from WAIT_MRS on): mode_reg <= addr[9:0]. CAS latency = mode_reg[6:4]; 2 or 3 accepted, else err_mode and CL treated as 2. Burst length mode_reg[2:0] must be 000, else err_mode; always single-word access. MRS with any bank open sets err_ref_open-like err_act_open? No: MRS with a bank open sets err_act_open.
- Bank tracking: per-bank open flag + row register. ACT to closed bank: open, latch addr[ROW_WIDTH-1:0]. ACT to open bank: err_act_open, row unchanged. PRE: addr[10]=1 closes all, else closes bank_addr bank; PRE to closed bank legal.
- READ/WRITE to closed bank: err_no_row; write dropped, read returns 16'h0000 with data_oe asserted normally.
- Word index = {bank, row, addr[COL_WIDTH-1:0]} truncated to low MEM_ADDR_WIDTH bits.
- WRITE: data_in sampled in the command cycle; byte [7:0] written unless data_mask_low, [15:8] unless data_mask_high.
- READ: memory read in the command cycle (write after read in pipeline does not affect it).
- addr[10]=1 on READ/WRITE: bank closed after the access.
- REF in READY: refresh_count += 1 (saturate 16'hFFFF); any bank open -> err_ref_open.
- Errors clear only on rst.

## Timing
- Reset values: data_out=0, data_oe=0, init_done=0, mode_reg=0, refresh_count=0, all errors 0, all banks closed, init FSM WAIT_PALL, read pipeline empty. Backing memory not cleared.
- READ at cycle T -> data_out/data_oe valid for exactly cycle T+CL (CL from mode_reg at T), one cycle wide. Pipeline is 3 deep; back-to-back READs every cycle return back-to-back data.
- data_out holds last value when data_oe=0.
- Status/flag outputs update the cycle after the causing command.
- rst asserted mid-read: pending read data discarded, data_oe=0 the cycle after rst.
- Bank state changes take effect the cycle after the command; READ immediately after ACT to same bank is legal.

## Test plan
- PRE(a10=1), REF, REF, MRS addr=10'b0000100000 -> init_done=1, CL=2, no errors; ACT before PRE -> err_not_init=1.
- After init: ACT bank1 row 5, WRITE col 3 data 16'hBEEF, READ col 3 at T -> data_out=16'hBEEF, data_oe=1 at T+2 only.
- MRS with mode_reg[6:4]=3 -> same read appears at T+3; mode_reg[2:0]=001 -> err_mode=1.
- WRITE 16'h1234 over 16'hBEEF with data_mask_high=1 -> read returns 16'hBE34.
- READ bank2 without ACT -> err_no_row=1, data_out=0 at T+2; ACT bank1 twice -> err_act_open=1.
- WRITE with addr[10]=1 then REF -> bank closed, err_ref_open stays 0, refresh_count increments by 1.
